serializer: RTL
===============

Name: serializer

Overview:
- Parallel-to-serial converter; direct upstream counterpart of the deserializer stage.
- Accepts one parallel word plus a valid-bit count, then shifts the bits out one per clock, MSB first, with a per-bit valid strobe.
- Its serial output is what the deserializer's serial input consumes; together they form the loopback pair used in system test.

Parameters:
- DATA_BUS_WIDTH, 16, width of the parallel input word; must be >= 4.
- DATA_MOD_WIDTH, $clog2(DATA_BUS_WIDTH), width of the bit-count field.

Ports:
- clk_i  input  1  single clock; all logic on posedge.
- srst_i  input  1  synchronous reset, active-high.
- data_i  input  DATA_BUS_WIDTH  parallel word to serialize.
- data_mod_i  input  DATA_MOD_WIDTH  number of valid bits, taken from the MSB end; 0 means full width.
- data_val_i  input  1  request strobe; sampled with data_i and data_mod_i.
- ser_data_o  output  1  serial data bit.
- ser_data_val_o  output  1  ser_data_o carries a valid bit this cycle.
- busy_o  output  1  a word is being shifted; new requests are ignored.

Behaviour:
- Interface: one clock (clk_i); reset srst_i is synchronous and active-high.
- Reset values: ser_data_o=0, ser_data_val_o=0, busy_o=0, FSM=IDLE, bit counter=0, shift register=0.
- FSM has two states, IDLE and SEND.
- Acceptance: a request is accepted when data_val_i=1, busy_o=0 and the decoded length N is valid.
  - N = DATA_BUS_WIDTH if data_mod_i=0, else N = data_mod_i.
  - N=1 or N=2 is invalid. The request is silently dropped: no output, busy_o stays 0, FSM stays IDLE.
- On acceptance: data_i is latched into the shift register, the counter is loaded with N, and the FSM goes IDLE->SEND.
  - data_i and data_mod_i are don't-care after the acceptance cycle.
- Latency: the first bit, data_i[DATA_BUS_WIDTH-1], appears on ser_data_o with ser_data_val_o=1 in the cycle after acceptance.
- SEND state:
  - Each cycle outputs the current MSB of the shift register with ser_data_val_o=1, then shifts left and decrements the counter.
  - Bits are output in the order data_i[W-1], data_i[W-2], ..., data_i[W-N].
  - ser_data_val_o is high for exactly N consecutive cycles.
  - SEND->IDLE after the N-th bit is output.
- busy_o is high exactly in the cycles where ser_data_val_o=1 (all N cycles, including the last bit).
- data_val_i while busy_o=1: ignored entirely. No queuing; the in-flight word is unaffected.
- Back-to-back words: the earliest next acceptance is the cycle after the last bit, so there is one idle cycle between words on the serial output.
- When ser_data_val_o=0, ser_data_o is driven 0.
- Reset mid-operation: the transfer aborts. The cycle after srst_i is asserted, all outputs are at reset values; remaining bits are discarded and never emitted.
- srst_i has priority over a simultaneous data_val_i; the request is dropped.
- Bits of data_i below position W-N are never output.
- Counter is DATA_MOD_WIDTH+1 bits so it can hold the value DATA_BUS_WIDTH without wrap-around.

Optional Feature:
- Macro: SERIALIZER_LSB_FIRST_EN.
- Defined:
  - Bit order is reversed: the valid bits are the N LSBs, data_i[N-1:0].
  - Output order is data_i[0] first through data_i[N-1].
  - The shift register shifts right.
  - Timing, busy_o, the handshake and length decoding are unchanged.
- Undefined: MSB-first behaviour as above (default build; the deserializer expects MSB-first).

Test Plan:
- Full word: data_i=16'hA5C3, data_mod_i=0, 1-cycle data_val_i -> from the next cycle, 16 valid cycles with bits 1010_0101_1100_0011; busy_o high for exactly those 16 cycles, then 0.
- Partial word: data_i=16'hF800, data_mod_i=5 -> 5 valid cycles all 1, then ser_data_val_o=0; data_i=16'h07FF, data_mod_i=3 -> 3 valid cycles all 0.
- Invalid length: data_mod_i=1, then data_mod_i=2, each with data_val_i=1 -> ser_data_val_o and busy_o stay 0 for 20 cycles.
- Ignore while busy: start 16'hFFFF mod 0; at bit 4 pulse data_val_i with 16'h0000 mod 0 -> the original 16 ones complete unaltered, and no second word follows.
- Reset mid-word: start 16'hAAAA mod 0; assert srst_i for 1 cycle at bit 7 -> next cycle all outputs 0; no further valid bits; a fresh request afterwards serializes normally.
- Back-to-back: hold data_val_i=1 with mod 4, data 16'hC000 then 16'h3000 -> serial output 1100, one idle cycle, then 0011.

Source files
------------

// File: rtl/serializer.sv
`default_nettype none
// ============================================================================
// serializer : parallel-to-serial converter, N valid bits out one per clock.
// Option SERIALIZER_LSB_FIRST_EN : emit the N LSBs, bit 0 first (default MSB-first)
// Revision   : 1.0
// ============================================================================
module serializer #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  input  logic [DATA_MOD_WIDTH-1:0] data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  localparam int CNT_W = DATA_MOD_WIDTH + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [DATA_BUS_WIDTH-1:0] r_shift;
  logic [DATA_BUS_WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0]          r_cnt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  logic [CNT_W-1:0]          w_len;
  logic                      w_accept;
  logic                      w_out_bit;
  logic [DATA_BUS_WIDTH-1:0] w_shifted;

  // A zero length field encodes a full-width word.
  assign w_len    = (data_mod_i == '0) ? CNT_W'(DATA_BUS_WIDTH) : {1'b0, data_mod_i};
  assign w_accept = data_val_i && (r_state == ST_IDLE) && (w_len > CNT_W'(2));

`ifdef SERIALIZER_LSB_FIRST_EN
  assign w_out_bit = r_shift[0];
  assign w_shifted = {1'b0, r_shift[DATA_BUS_WIDTH-1:1]};
`else
  assign w_out_bit = r_shift[DATA_BUS_WIDTH-1];
  assign w_shifted = {r_shift[DATA_BUS_WIDTH-2:0], 1'b0};
`endif

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state <= ST_IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_shift_nxt = data_i;
          w_cnt_nxt   = w_len;
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        w_shift_nxt = w_shifted;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        // The bit on the output this cycle is the last one of the word.
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign ser_data_val_o = (r_state == ST_SEND);
  assign busy_o         = (r_state == ST_SEND);
  assign ser_data_o     = (r_state == ST_SEND) && w_out_bit;

endmodule
`default_nettype wire
